display_scan_ctrl: RTL and testbench

//  Scan controller that time-shares the single 7-segment decoder between the ones and tens digits.

---
 rtl/display_pkg.sv | 19 +
 rtl/scan_timer.sv | 38 +++
 rtl/display_scan_ctrl.sv | 105 ++++++++++
 tb/tb_display_scan_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared FSM states and anode bit indices for the display scan controller
package display_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ONES_BLANK,
    ONES_ON,
    TENS_BLANK,
    TENS_ON
  } scan_state_t;

  localparam int DIG_ONES = 0;
  localparam int DIG_TENS = 1;

  function automatic logic [1:0] anode_drive(input logic [1:0] lit, input bit active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - per-slot cycle counter with blank/slot end strobes
module scan_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    // Held at zero while idle so a fresh frame always starts counting from slot start
    if (!active_i || cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign blank_done_o = (cnt_q == BLANK_END);
  assign slot_done_o  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - time-shares one 7-segment decoder between ones and tens digits
// Optional build macro LEADING_ZERO_BLANK_EN: keep the tens anode dark when the latched tens value is 0.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] ones_in,
  input  logic [2:0] tens_in,
  output logic [3:0] ones_out,
  output logic [2:0] tens_out,
  output logic       sel_ones,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam logic [1:0] AN_OFF = ANODE_ACTIVE_LOW ? 2'b11 : 2'b00;

  scan_state_t state_q, state_d;
  logic [3:0]  ones_q, ones_d;
  logic [2:0]  tens_q, tens_d;
  logic        sel_q, sel_d;
  logic [1:0]  an_q, an_d;
  logic        tick_q, tick_d;
  logic [1:0]  lit;
  logic        new_frame;
  logic        blank_done, slot_done;

  scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (reset),
    .active_i    ((state_q != IDLE) && run),
    .blank_done_o(blank_done),
    .slot_done_o (slot_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (run)        state_d = ONES_BLANK;
      ONES_BLANK: if (blank_done) state_d = ONES_ON;
      ONES_ON:    if (slot_done)  state_d = TENS_BLANK;
      TENS_BLANK: if (blank_done) state_d = TENS_ON;
      TENS_ON:    if (slot_done)  state_d = ONES_BLANK;
      default:                    state_d = IDLE;
    endcase
    if (state_q != IDLE && !run) begin
      state_d = IDLE;
    end
  end

  // Outputs are computed from the next state so they change on the edge entering it
  always_comb begin
    new_frame = (state_d == ONES_BLANK) && (state_q != ONES_BLANK);
    ones_d    = new_frame ? ones_in : ones_q;
    tens_d    = new_frame ? tens_in : tens_q;
    tick_d    = new_frame;
    sel_d     = !(state_d == TENS_BLANK || state_d == TENS_ON);
    lit       = 2'b00;
    if (state_d == ONES_ON) begin
      lit[DIG_ONES] = 1'b1;
    end
    if (state_d == TENS_ON) begin
`ifdef LEADING_ZERO_BLANK_EN
      lit[DIG_TENS] = (tens_d != 3'd0);
`else
      lit[DIG_TENS] = 1'b1;
`endif
    end
    an_d = anode_drive(lit, ANODE_ACTIVE_LOW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ones_q  <= '0;
      tens_q  <= '0;
      sel_q   <= 1'b1;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign ones_out   = ones_q;
  assign tens_out   = tens_q;
  assign sel_ones   = sel_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [3:0] ones_in;
  logic [2:0] tens_in;
  logic [3:0] ones_out;
  logic [2:0] tens_out;
  logic       sel_ones;
  logic [1:0] an;
  logic       frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  logic prev_sel;

  display_scan_ctrl #(
    .REFRESH_DIV     (8),
    .BLANK_CYCLES    (2),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .ones_in   (ones_in),
    .tens_in   (tens_in),
    .ones_out  (ones_out),
    .tens_out  (tens_out),
    .sel_ones  (sel_ones),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected anodes at position p (0..15) within a frame, active-low
  function automatic logic [1:0] exp_an(input int p, input bit tens_dark);
    if (p < 2)  return 2'b11;
    if (p < 8)  return 2'b10;
    if (p < 10) return 2'b11;
    return tens_dark ? 2'b11 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Per-cycle scan checks plus the sel/anode safety invariants
  task automatic chk_frame(input int p, input bit tens_dark, input logic [3:0] e_ones,
                           input logic [2:0] e_tens);
    chk("an", {6'd0, an}, {6'd0, exp_an(p, tens_dark)});
    chk("frame_tick", {7'd0, frame_tick}, {7'd0, (p == 0)});
    chk("sel_ones", {7'd0, sel_ones}, {7'd0, (p < 8)});
    chk("ones_out", {4'd0, ones_out}, {4'd0, e_ones});
    chk("tens_out", {5'd0, tens_out}, {5'd0, e_tens});
    chk("an_not_00", {7'd0, (an !== 2'b00)}, 8'd1);
    if (sel_ones !== prev_sel) begin
      chk("sel_change_dark", {6'd0, an}, 8'h03);
    end
    prev_sel = sel_ones;
  endtask

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    ones_in = 4'd0;
    tens_in = 3'd0;
    repeat (3) step();
    chk("rst_an", {6'd0, an}, 8'h03);
    chk("rst_sel", {7'd0, sel_ones}, 8'd1);
    chk("rst_ones", {4'd0, ones_out}, 8'd0);
    chk("rst_tens", {5'd0, tens_out}, 8'd0);
    chk("rst_tick", {7'd0, frame_tick}, 8'd0);
    prev_sel = sel_ones;

    reset   = 1'b0;
    run     = 1'b1;
    ones_in = 4'd7;
    tens_in = 3'd3;
    for (int k = 0; k <= 36; k++) begin
      step();
      if (k == 20) ones_in = 4'd8;
      chk_frame(k % 16, 1'b0, (k >= 32) ? 4'd8 : 4'd7, 3'd3);
    end

    // k=36 is mid ONES_ON; stop scanning
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stop_an", {6'd0, an}, 8'h03);
      chk("stop_sel", {7'd0, sel_ones}, 8'd1);
      chk("stop_tick", {7'd0, frame_tick}, 8'd0);
      chk("stop_ones", {4'd0, ones_out}, 8'd8);
    end
    prev_sel = sel_ones;

    run     = 1'b1;
    ones_in = 4'd5;
    tens_in = 3'd0;
    for (int k = 0; k <= 27; k++) begin
      step();
      if (k == 5) tens_in = 3'd4;
      chk_frame(k % 16, (k < 16) ? LZB : 1'b0, 4'd5, (k < 16) ? 3'd0 : 3'd4);
    end

    // Now in TENS_ON with tens=4 lit; reset asynchronously between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_an", {6'd0, an}, 8'h03);
    chk("arst_sel", {7'd0, sel_ones}, 8'd1);
    chk("arst_ones", {4'd0, ones_out}, 8'd0);
    chk("arst_tens", {5'd0, tens_out}, 8'd0);
    chk("arst_tick", {7'd0, frame_tick}, 8'd0);
    run = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("idle_an", {6'd0, an}, 8'h03);
    chk("idle_tick", {7'd0, frame_tick}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
